// File: rtl/load_store_unit.sv
// Load/store unit: drives a word-addressed single-port data memory, doing sub-word stores by read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned half/word accesses into error responses instead of aligning them.
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] address,
    output logic [31:0] data_input,
    input  logic [31:0] data_output
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        RMW_RD,
        RMW_WAIT,
        WR
    } state_t;

    localparam logic [1:0]  SIZE_BYTE  = 2'b00;
    localparam logic [1:0]  SIZE_HALF  = 2'b01;
    localparam logic [1:0]  SIZE_WORD  = 2'b10;
    localparam logic [32:0] BYTE_LIMIT = 33'(MEM_WORDS) << 2;

    state_t      state, state_next;

    logic [1:0]  lat_size, lat_size_next;
    logic        lat_unsigned, lat_unsigned_next;
    logic [1:0]  lat_lane, lat_lane_next;
    logic [15:0] lat_wdata, lat_wdata_next;

    logic        req_ready_next;
    logic        resp_valid_next;
    logic [31:0] resp_rdata_next;
    logic        resp_err_next;
    logic        mem_read_next;
    logic        mem_write_next;
    logic [31:0] address_next;
    logic [31:0] data_input_next;

    logic        req_error;
    logic [1:0]  aligned_lane;
    logic [31:0] load_data;
    logic [31:0] merged_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Misaligned low address bits are dropped here; in trap mode such requests never reach memory anyway.
    always_comb begin
        case (req_size)
            SIZE_BYTE: aligned_lane = req_addr[1:0];
            SIZE_HALF: aligned_lane = {req_addr[1], 1'b0};
            default:   aligned_lane = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((req_size == SIZE_HALF) && req_addr[0]) ||
                        ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
    assign req_error  = (req_size == 2'b11) || ({1'b0, req_addr} >= BYTE_LIMIT) || misaligned;
`else
    assign req_error  = (req_size == 2'b11) || ({1'b0, req_addr} >= BYTE_LIMIT);
`endif

    assign byte_sel = data_output[{lat_lane, 3'b000} +: 8];
    assign half_sel = data_output[{lat_lane[1], 4'b0000} +: 16];

    always_comb begin
        case (lat_size)
            SIZE_BYTE: load_data = {{24{~lat_unsigned & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data = {{16{~lat_unsigned & half_sel[15]}}, half_sel};
            default:   load_data = data_output;
        endcase
    end

    always_comb begin
        merged_word = data_output;
        if (lat_size == SIZE_BYTE) begin
            merged_word[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
        end else begin
            merged_word[{lat_lane[1], 4'b0000} +: 16] = lat_wdata;
        end
    end

    // Every output is registered, so the next-state logic also computes the next value of each output.
    always_comb begin
        state_next        = state;
        lat_size_next     = lat_size;
        lat_unsigned_next = lat_unsigned;
        lat_lane_next     = lat_lane;
        lat_wdata_next    = lat_wdata;
        resp_valid_next   = 1'b0;
        resp_rdata_next   = 32'd0;
        resp_err_next     = 1'b0;
        mem_read_next     = 1'b0;
        mem_write_next    = 1'b0;
        address_next      = address;
        data_input_next   = data_input;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    lat_size_next     = req_size;
                    lat_unsigned_next = req_unsigned;
                    lat_lane_next     = aligned_lane;
                    lat_wdata_next    = req_wdata[15:0];
                    if (req_error) begin
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b1;
                    end else begin
                        address_next = {2'b00, req_addr[31:2]};
                        if (!req_write) begin
                            state_next    = RD;
                            mem_read_next = 1'b1;
                        end else if (req_size == SIZE_WORD) begin
                            state_next      = WR;
                            mem_write_next  = 1'b1;
                            data_input_next = req_wdata;
                        end else begin
                            state_next    = RMW_RD;
                            mem_read_next = 1'b1;
                        end
                    end
                end
            end
            RD: begin
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                state_next      = IDLE;
                resp_valid_next = 1'b1;
                resp_rdata_next = load_data;
            end
            RMW_RD: begin
                state_next = RMW_WAIT;
            end
            RMW_WAIT: begin
                state_next      = WR;
                mem_write_next  = 1'b1;
                data_input_next = merged_word;
            end
            WR: begin
                state_next      = IDLE;
                resp_valid_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        req_ready_next = (state_next == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_lane     <= 2'b00;
            lat_wdata    <= 16'd0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'd0;
            resp_err     <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            address      <= 32'd0;
            data_input   <= 32'd0;
        end else begin
            state        <= state_next;
            lat_size     <= lat_size_next;
            lat_unsigned <= lat_unsigned_next;
            lat_lane     <= lat_lane_next;
            lat_wdata    <= lat_wdata_next;
            req_ready    <= req_ready_next;
            resp_valid   <= resp_valid_next;
            resp_rdata   <= resp_rdata_next;
            resp_err     <= resp_err_next;
            mem_read     <= mem_read_next;
            mem_write    <= mem_write_next;
            address      <= address_next;
            data_input   <= data_input_next;
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port: accepts one load/store request at a time from the CPU MEM stage and drives the word-addressed, single-port data memory (`mem_read`, `mem_write`, `address`, `data_input`, `data_output`). It converts byte addresses to word indices, performs sub-word stores by read-modify-write, and sign- or zero-extends sub-word loads. It returns one response per request; memory access is never overlapped.

## Interface

Parameters:
- `MEM_WORDS`, 1024: memory depth in 32-bit words; power of two; byte range is 0 .. 4*MEM_WORDS-1.

Ports:
- `clk`  in  1  rising-edge clock, shared with data memory.
- `reset`  in  1  synchronous, active-high; shared with data memory.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads: 1 zero-extend, 0 sign-extend.
- `req_addr`  in  32  byte address, little-endian.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  one-cycle pulse per accepted request.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  valid with `resp_valid`; request rejected, no memory access made.
- `mem_read`  out  1  to memory.
- `mem_write`  out  1  to memory.
- `address`  out  32  word index = `req_addr[31:2]`, upper bits zero.
- `data_input`  out  32  word to write.
- `data_output`  in  32  memory read data, registered inside the memory (valid the cycle after the `mem_read` edge).

## Operation

- States: IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR.
- Error at acceptance (any of): `req_size`==11; `req_addr >= 4*MEM_WORDS`; misalignment (see Configuration). Response pulses next cycle with `resp_err`=1, `resp_rdata`=0; state stays IDLE; no `mem_*` strobe.
- Word/sub-word load: IDLE -> RD (`mem_read`=1) -> RD_WAIT (strobes 0) -> IDLE, capturing `data_output`. Lane select is `addr[1:0]` for byte and `addr[1]` for half. Extend per `req_unsigned`.
- Word store: IDLE -> WR (`mem_write`=1, `data_input`=`req_wdata`) -> IDLE with response.
- Byte/half store: IDLE -> RMW_RD (`mem_read`=1) -> RMW_WAIT -> WR. In WR, `data_input` is the captured word with the addressed lane(s) replaced by `req_wdata` low bits.
- `mem_read` and `mem_write` are never high in the same cycle; the memory gives read priority, so overlap would drop a write.
- All request fields are latched at acceptance; later changes on `req_*` are ignored until the next acceptance.

## Timing

- All outputs are registered. E0 = acceptance edge.
- Load: `mem_read` high in cycle E0..E1. Response cycle E2..E3; `req_ready` is high in the same cycle, so back-to-back requests are allowed.
- Word store: `mem_write` high in E0..E1; response in E1..E2.
- Sub-word store: `mem_read` high in E0..E1; `mem_write` high in E2..E3; response in E3..E4.
- Error: response in E0..E1.
- Reset values: `req_ready`=1 after the reset edge; all other outputs are 0; state is IDLE.
- Reset mid-operation aborts with no response. Because `reset` is shared, the memory also suppresses any write strobed in that cycle.

## Configuration

- `LSU_MISALIGN_TRAP_EN` defined: a half access with `addr[0]`=1, or a word access with `addr[1:0]`!=0, produces an error response.
- Undefined: misaligned low bits are silently forced to zero (half clears bit 0, word clears bits 1:0). The access proceeds aligned with no error.

## Test plan

- Word store 0xDEADBEEF @0x10, then word load @0x10 -> `address`=4, load `resp_rdata`=0xDEADBEEF two cycles after acceptance.
- Byte store 0x80 @0x11 over 0xDEADBEEF, then signed byte load @0x11 -> memory word 0xDEAD80EF, `resp_rdata`=0xFFFFFF80. Unsigned byte load -> 0x00000080.
- Half store 0x1234 @0x12, then signed half load @0x12 -> word 0x123480EF, `resp_rdata`=0x00001234. Check that `mem_read`/`mem_write` never overlap.
- Load @0x1000 (MEM_WORDS=1024), and a request with `req_size`=11 -> `resp_err`=1 next cycle, no strobe.
- Word load @0x12: with `LSU_MISALIGN_TRAP_EN` -> `resp_err`=1. Without it -> reads word 4, returns 0x123480EF.
- Assert `reset` during RMW_WAIT of a byte store -> no `resp_valid`, no `mem_write`, memory word unchanged, `req_ready`=1 next cycle.
